// File: rtl/controle_pedagio_pkg.sv
// Shared definitions for the toll-lane controller: FSM states, category codes,
// default tariffs and small arithmetic helpers.
package controle_pedagio_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        COBRANDO = 2'd2,
        LIBERADO = 2'd3
    } estado_t;

    localparam logic [1:0] CAT_2EIXOS = 2'd0;
    localparam logic [1:0] CAT_3EIXOS = 2'd1;
    localparam logic [1:0] CAT_4EIXOS = 2'd2;
    localparam logic [1:0] CAT_5EIXOS = 2'd3;

    localparam logic [3:0] TARIFA_C0_DEF   = 4'd2;
    localparam logic [3:0] TARIFA_C1_DEF   = 4'd4;
    localparam logic [3:0] TARIFA_C2_DEF   = 4'd6;
    localparam logic [3:0] TARIFA_C3_DEF   = 4'd9;
    localparam int         GATE_CYCLES_DEF = 8;

    // Zero or one axle is treadle noise or a motorcycle and falls in the lowest class.
    function automatic logic [1:0] classifica(input logic [2:0] eixos);
        logic [1:0] cat;
        case (eixos)
            3'd0, 3'd1, 3'd2: cat = CAT_2EIXOS;
            3'd3:             cat = CAT_3EIXOS;
            3'd4:             cat = CAT_4EIXOS;
            default:          cat = CAT_5EIXOS;
        endcase
        return cat;
    endfunction

    function automatic logic [3:0] soma_sat(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] soma;
        soma = {1'b0, a} + {1'b0, b};
        return soma[4] ? 4'd15 : soma[3:0];
    endfunction

endpackage

// File: rtl/controle_pedagio_sincroniza_borda.sv
// Two-flop synchroniser for a raw asynchronous sensor followed by a registered
// edge detector producing one-cycle rise and fall pulses.
module sincroniza_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic entrada,
    output logic sobe,
    output logic desce
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchroniser chain, previous-value flop and registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            sobe    <= 1'b0;
            desce   <= 1'b0;
        end else begin
            sync1_r <= entrada;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            sobe    <= sync2_r & ~prev_r;
            desce   <= ~sync2_r & prev_r;
        end
    end

endmodule

// File: rtl/controle_pedagio.sv
// Toll-lane controller: classifies vehicles by axle count, accumulates coins
// and opens the gate once the category tariff is covered.
module controle_pedagio
    import controle_pedagio_pkg::*;
#(
    parameter logic [3:0] TARIFA_C0   = TARIFA_C0_DEF,
    parameter logic [3:0] TARIFA_C1   = TARIFA_C1_DEF,
    parameter logic [3:0] TARIFA_C2   = TARIFA_C2_DEF,
    parameter logic [3:0] TARIFA_C3   = TARIFA_C3_DEF,
    parameter int         GATE_CYCLES = GATE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_eixo,
    input  logic       sensor_presenca,
    input  logic       moeda_valida,
    input  logic [3:0] moeda_valor,
    output logic       E1,
    output logic       E0,
    output logic [3:0] P,
    output logic       cancela,
    output logic       cobrando
);

    localparam logic [7:0] GATE_ULTIMO = 8'(GATE_CYCLES - 1);

    estado_t    estado_r;
    estado_t    estado_next_s;
    logic [2:0] eixos_r;
    logic [2:0] eixos_next_s;
    logic [2:0] eixos_inc_s;
    logic [7:0] gate_cnt_r;
    logic [7:0] gate_next_s;
    logic [1:0] cat_next_s;
    logic [3:0] p_next_s;
    logic [3:0] tarifa_s;
    logic       cancela_next_s;
    logic       cobrando_next_s;
    logic       eixo_sobe_s;
    logic       eixo_desce_unused_s;
    logic       pres_sobe_s;
    logic       pres_desce_s;

    sincroniza_borda u_sinc_eixo (
        .clk     (clk),
        .rst_n   (rst_n),
        .entrada (sensor_eixo),
        .sobe    (eixo_sobe_s),
        .desce   (eixo_desce_unused_s)
    );

    sincroniza_borda u_sinc_presenca (
        .clk     (clk),
        .rst_n   (rst_n),
        .entrada (sensor_presenca),
        .sobe    (pres_sobe_s),
        .desce   (pres_desce_s)
    );

    // Tariff of the latched category and saturating axle increment.
    always_comb begin
        case ({E1, E0})
            CAT_2EIXOS: tarifa_s = TARIFA_C0;
            CAT_3EIXOS: tarifa_s = TARIFA_C1;
            CAT_4EIXOS: tarifa_s = TARIFA_C2;
            default:    tarifa_s = TARIFA_C3;
        endcase
        if (eixo_sobe_s && (eixos_r != 3'd7)) begin
            eixos_inc_s = eixos_r + 3'd1;
        end else begin
            eixos_inc_s = eixos_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= estado_next_s;
        end
    end

    // FSM next-state logic; presence edges outside OCIOSO/CONTANDO are ignored.
    always_comb begin
        estado_next_s = estado_r;
        case (estado_r)
            OCIOSO:   if (pres_sobe_s)              estado_next_s = CONTANDO; else estado_next_s = OCIOSO;
            CONTANDO: if (pres_desce_s)             estado_next_s = COBRANDO; else estado_next_s = CONTANDO;
            COBRANDO: if (P >= tarifa_s)            estado_next_s = LIBERADO; else estado_next_s = COBRANDO;
            LIBERADO: if (gate_cnt_r == GATE_ULTIMO) estado_next_s = OCIOSO;  else estado_next_s = LIBERADO;
            default:  estado_next_s = OCIOSO;
        endcase
    end

    // Next values of the datapath and registered outputs.
    always_comb begin
        eixos_next_s = eixos_r;
        cat_next_s   = {E1, E0};
        p_next_s     = P;
        gate_next_s  = gate_cnt_r;
        case (estado_r)
            OCIOSO: begin
                eixos_next_s = 3'd0;
                cat_next_s   = CAT_2EIXOS;
                p_next_s     = 4'd0;
                gate_next_s  = 8'd0;
            end
            CONTANDO: begin
                eixos_next_s = eixos_inc_s;
                // Same-cycle axle pulse is included before classification.
                if (pres_desce_s) cat_next_s = classifica(eixos_inc_s); else cat_next_s = {E1, E0};
            end
            COBRANDO: begin
                gate_next_s = 8'd0;
                if (moeda_valida) p_next_s = soma_sat(P, moeda_valor); else p_next_s = P;
            end
            LIBERADO: begin
                gate_next_s = gate_cnt_r + 8'd1;
                if (gate_cnt_r == GATE_ULTIMO) begin
                    cat_next_s = CAT_2EIXOS;
                    p_next_s   = 4'd0;
                end else begin
                    cat_next_s = {E1, E0};
                    p_next_s   = P;
                end
            end
            default: begin
                eixos_next_s = 3'd0;
            end
        endcase
        cancela_next_s  = (estado_next_s == LIBERADO);
        cobrando_next_s = (estado_next_s == COBRANDO);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eixos_r    <= 3'd0;
            gate_cnt_r <= 8'd0;
            E1         <= 1'b0;
            E0         <= 1'b0;
            P          <= 4'd0;
            cancela    <= 1'b0;
            cobrando   <= 1'b0;
        end else begin
            eixos_r    <= eixos_next_s;
            gate_cnt_r <= gate_next_s;
            E1         <= cat_next_s[1];
            E0         <= cat_next_s[0];
            P          <= p_next_s;
            cancela    <= cancela_next_s;
            cobrando   <= cobrando_next_s;
        end
    end

endmodule
